// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for the shared AD/FRAME_B/IRDY_B/TRDY_B bus that the
//   CPU and DSP masters share. It issues one active-low grant at a time and
//   holds it for exactly one bus transaction. Two watchdogs stop a dead master
//   from locking the bus. The first one limits how long a granted master may
//   wait before asserting FRAME_B. The second limits how long a started
//   transaction may take to finish its data phase.
//
// Ports
//   i_clk        bus clock, everything happens on the rising edge
//   i_rst        synchronous active-high reset
//   i_req_b      per-master request, active low
//   i_frame_b    shared FRAME_B, active low, pulled up when released
//   i_irdy_b     shared IRDY_B, active low, pulled up when released
//   i_trdy_b     shared TRDY_B, active low, pulled up when released
//   o_gnt_b      per-master grant, active low, at most one bit low
//   o_bus_busy   high while in GRANT, BUSY or TURNAROUND
//   o_cur_owner  index of the current or most recent grantee
//   o_timeout    one-cycle pulse when either watchdog fires
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = 16,
    parameter int TXN_TIMEOUT = 64
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst,
    input  logic [N_MASTERS-1:0]                                 i_req_b,
    input  logic                                                 i_frame_b,
    input  logic                                                 i_irdy_b,
    input  logic                                                 i_trdy_b,
    output logic [N_MASTERS-1:0]                                 o_gnt_b,
    output logic                                                 o_bus_busy,
    output logic [((N_MASTERS > 1) ? $clog2(N_MASTERS) : 1)-1:0] o_cur_owner,
    output logic                                                 o_timeout
);

    localparam int OW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int MAX_T = (GNT_TIMEOUT > TXN_TIMEOUT) ? GNT_TIMEOUT : TXN_TIMEOUT;
    localparam int CW    = $clog2(MAX_T + 1);

    // Each watchdog fires on the edge where its counter would reach the limit.
    localparam logic [CW-1:0] GNT_LIMIT   = CW'(GNT_TIMEOUT - 1);
    localparam logic [CW-1:0] TXN_LIMIT   = CW'(TXN_TIMEOUT - 1);
    localparam logic [OW-1:0] LAST_MASTER = OW'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_TURNAROUND
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [N_MASTERS-1:0]   r_gntB;
    logic                   r_busy;
    logic [OW-1:0]          r_ptr;
    logic                   r_timeout;

    state_t                 w_nextState;
    logic [CW-1:0]          w_nextCnt;
    logic [N_MASTERS-1:0]   w_nextGntB;
    logic [OW-1:0]          w_nextPtr;
    logic                   w_nextTimeout;

    logic [N_MASTERS-1:0]   w_reqAct;
    logic                   w_frameAct;
    logic                   w_irdyAct;
    logic                   w_trdyAct;
    logic                   w_anyReq;
    logic [OW-1:0]          w_winner;
    int                     w_idx;

    // Only a cleanly sampled 0 counts as asserted. A floating (Z) or unknown
    // (X) line is treated as released, so a half-driven bus cannot start or
    // finish a transaction.
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            w_reqAct[i] = (i_req_b[i] === 1'b0);
        end
        w_frameAct = (i_frame_b === 1'b0);
        w_irdyAct  = (i_irdy_b === 1'b0);
        w_trdyAct  = (i_trdy_b === 1'b0);
    end

    // Round-robin search. It starts at the slot after the last winner and
    // wraps around, so the most recent owner has the lowest priority.
    always_comb begin
        w_anyReq = 1'b0;
        w_winner = r_ptr;
        w_idx    = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_idx = (int'(r_ptr) + k) % N_MASTERS;
            if (!w_anyReq && w_reqAct[w_idx]) begin
                w_anyReq = 1'b1;
                w_winner = OW'(w_idx);
            end
        end
    end

    // Next-state logic. Register values are computed here so that every
    // output comes straight from a flop.
    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_cnt;
        w_nextGntB    = r_gntB;
        w_nextPtr     = r_ptr;
        w_nextTimeout = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_nextGntB = '1;
                if (w_anyReq) begin
                    w_nextGntB[w_winner] = 1'b0;
                    w_nextPtr            = w_winner;
                    w_nextCnt            = '0;
                    w_nextState          = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // FRAME_B has priority over the watchdog. A master that
                // starts on the last allowed cycle keeps its grant.
                if (w_frameAct) begin
                    w_nextCnt   = '0;
                    w_nextState = ST_BUSY;
                end else if (r_cnt >= GNT_LIMIT) begin
                    w_nextGntB    = '1;
                    w_nextTimeout = 1'b1;
                    w_nextCnt     = '0;
                    w_nextState   = ST_TURNAROUND;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            ST_BUSY: begin
                // Completion has priority over the watchdog. When IRDY_B is
                // asserted without TRDY_B, that is only a wait state.
                if (w_irdyAct && w_trdyAct) begin
                    w_nextGntB  = '1;
                    w_nextCnt   = '0;
                    w_nextState = ST_TURNAROUND;
                end else if (r_cnt >= TXN_LIMIT) begin
                    w_nextGntB    = '1;
                    w_nextTimeout = 1'b1;
                    w_nextCnt     = '0;
                    w_nextState   = ST_TURNAROUND;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            ST_TURNAROUND: begin
                w_nextGntB  = '1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextGntB  = '1;
                w_nextCnt   = '0;
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset takes effect immediately, even in the
    // middle of a transaction, and does not wait for the bus to go idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gntB    <= '1;
            r_busy    <= 1'b0;
            r_ptr     <= LAST_MASTER;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_gntB    <= w_nextGntB;
            r_busy    <= (w_nextState != ST_IDLE);
            r_ptr     <= w_nextPtr;
            r_timeout <= w_nextTimeout;
        end
    end

    assign o_gnt_b     = r_gntB;
    assign o_bus_busy  = r_busy;
    assign o_cur_owner = r_ptr;
    assign o_timeout   = r_timeout;

endmodule
